// File: rtl/avalon_mem_agent_if.sv
// Avalon-MM agent bus bundle: command, write data and read return.
// master drives commands, slave answers with waitrequest/readdata.
interface avalon_mem_agent_if #(
  parameter int DATA_W = 128
);
  logic [31:0]         avs_address;
  logic [31:0]         avs_burstcount;
  logic                avs_write;
  logic [DATA_W-1:0]   avs_writedata;
  logic [DATA_W/8-1:0] avs_byteenable;
  logic                avs_read;
  logic                avs_waitrequest;
  logic [DATA_W-1:0]   avs_readdata;
  logic                avs_readdatavalid;

  modport master (
    output avs_address, avs_burstcount,
    output avs_write, avs_writedata,
    output avs_byteenable, avs_read,
    input  avs_waitrequest, avs_readdata,
    input  avs_readdatavalid
  );

  modport slave (
    input  avs_address, avs_burstcount,
    input  avs_write, avs_writedata,
    input  avs_byteenable, avs_read,
    output avs_waitrequest, avs_readdata,
    output avs_readdatavalid
  );
endinterface

// File: rtl/avalon_mem_agent.sv
// Avalon-MM burst memory agent with fixed-latency read pipeline.
// Ports: clk, rst (sync high), avs bus, beat counters, proto_err.
module avalon_mem_agent #(
  parameter int DATA_W       = 128,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2,
  parameter int MAX_BURST    = 64
) (
  input  logic                clk,
  input  logic                rst,
  avalon_mem_agent_if.slave   avs,
  output logic [15:0]         wr_beat_cnt,
  output logic [15:0]         rd_beat_cnt,
  output logic                proto_err
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_W / 8;
  localparam int LEN_W = $clog2(MAX_BURST) + 1;
  localparam int L     = READ_LATENCY;

  typedef enum logic [1:0] {
    IDLE, WR_BURST, RD_BURST
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   base_q, base_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               perr_q, perr_d;
  logic [15:0]        wcnt_q, wcnt_d;
  logic [15:0]        rcnt_q, rcnt_d;
  logic [L-1:0]       vld_q, vld_d;
  logic [DATA_W-1:0]  dat_q [L];
  logic [DATA_W-1:0]  dat_d [L];

  logic [DATA_W-1:0]  mem [DEPTH];

  logic               we, re;
  logic [IDX_W-1:0]   widx, ridx;
  logic [IDX_W-1:0]   cmd_idx, beat_idx;
  logic [LEN_W-1:0]   cmd_len;
  logic               cmd_big, last;
  logic               unused_addr;

  assign unused_addr = ^{avs.avs_address[31:IDX_W+4],
                         avs.avs_address[3:0]};

  assign cmd_idx  = avs.avs_address[IDX_W+3:4];
  assign cmd_big  = avs.avs_burstcount > 32'(MAX_BURST);
  assign beat_idx = base_q + IDX_W'(cnt_q);
  assign last     = cnt_q == len_q - 1'b1;

  always_comb begin
    cmd_len = avs.avs_burstcount[LEN_W-1:0];
    if (avs.avs_burstcount == '0) cmd_len = LEN_W'(1);
    if (cmd_big) cmd_len = LEN_W'(MAX_BURST);
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    perr_d  = perr_q;
    we      = 1'b0;
    re      = 1'b0;
    widx    = '0;
    ridx    = '0;
    unique case (state_q)
      IDLE: begin
        if (avs.avs_write) begin
          // a read in the same cycle is dropped
          we     = 1'b1;
          widx   = cmd_idx;
          base_d = cmd_idx;
          len_d  = cmd_len;
          cnt_d  = LEN_W'(1);
          if (cmd_len > LEN_W'(1)) state_d = WR_BURST;
          if (avs.avs_read || cmd_big) perr_d = 1'b1;
        end else if (avs.avs_read) begin
          re     = 1'b1;
          ridx   = cmd_idx;
          base_d = cmd_idx;
          len_d  = cmd_len;
          cnt_d  = LEN_W'(1);
          if (cmd_len > LEN_W'(1)) state_d = RD_BURST;
          if (cmd_big) perr_d = 1'b1;
        end
      end
      WR_BURST: begin
        if (avs.avs_read) perr_d = 1'b1;
        if (avs.avs_write) begin
          we    = 1'b1;
          widx  = beat_idx;
          cnt_d = cnt_q + 1'b1;
          if (last) state_d = IDLE;
        end
      end
      RD_BURST: begin
        re    = 1'b1;
        ridx  = beat_idx;
        cnt_d = cnt_q + 1'b1;
        if (last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // read pipeline; array read sees pre-write contents
  always_comb begin
    vld_d[0] = re;
    dat_d[0] = re ? mem[ridx] : '0;
    for (int i = 1; i < L; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  always_comb begin
    wcnt_d = wcnt_q;
    rcnt_d = rcnt_q;
    if (we && wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 1'b1;
    if (vld_q[L-1] && rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      perr_q  <= 1'b0;
      wcnt_q  <= '0;
      rcnt_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < L; i++) dat_q[i] <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      perr_q  <= perr_d;
      wcnt_q  <= wcnt_d;
      rcnt_q  <= rcnt_d;
      vld_q   <= vld_d;
      for (int i = 0; i < L; i++) dat_q[i] <= dat_d[i];
    end
  end

  // storage is never cleared; reset only blocks writes
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (avs.avs_byteenable[i])
          mem[widx][8*i +: 8] <= avs.avs_writedata[8*i +: 8];
      end
    end
  end

  assign avs.avs_waitrequest   = rst || state_q == RD_BURST;
  assign avs.avs_readdata      = dat_q[L-1];
  assign avs.avs_readdatavalid = vld_q[L-1];
  assign wr_beat_cnt           = wcnt_q;
  assign rd_beat_cnt           = rcnt_q;
  assign proto_err             = perr_q;
endmodule

// File: tb/tb_avalon_mem_agent.sv
// Directed bench for avalon_mem_agent: vector table plus burst,
// error and reset-abort sequences.
module tb_avalon_mem_agent;
  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic [15:0] wr_beat_cnt;
  logic [15:0] rd_beat_cnt;
  logic        proto_err;
  int          cyc;
  int          errors;
  int          checks;
  int          exp_wr;
  int          exp_rd;

  logic [127:0] rq_dat [$];
  int           rq_cyc [$];

  avalon_mem_agent_if #(.DATA_W(128)) m ();

  avalon_mem_agent #(
    .DATA_W(128), .DEPTH(256),
    .READ_LATENCY(LAT), .MAX_BURST(64)
  ) dut (
    .clk(clk),
    .rst(rst),
    .avs(m),
    .wr_beat_cnt(wr_beat_cnt),
    .rd_beat_cnt(rd_beat_cnt),
    .proto_err(proto_err)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
    logic [15:0]  be;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m.avs_readdatavalid) begin
      rq_dat.push_back(m.avs_readdata);
      rq_cyc.push_back(cyc);
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] pat(input int k);
    pat = {4{32'hB0B0_0000 | 32'(k)}};
  endfunction

  task automatic wr_beat(input logic [31:0] addr, input int bc,
                         input logic [127:0] d,
                         input logic [15:0] be);
    m.avs_address    = addr;
    m.avs_burstcount = 32'(bc);
    m.avs_writedata  = d;
    m.avs_byteenable = be;
    m.avs_write      = 1'b1;
    tick();
    m.avs_write = 1'b0;
    exp_wr++;
  endtask

  task automatic rd_cmd(input logic [31:0] addr, input int bc,
                        output int t);
    t = cyc;
    m.avs_address    = addr;
    m.avs_burstcount = 32'(bc);
    m.avs_read       = 1'b1;
    tick();
    m.avs_read = 1'b0;
  endtask

  task automatic single_read(input string name,
                             input logic [31:0] addr,
                             input logic [127:0] exp);
    int t;
    rq_dat.delete();
    rq_cyc.delete();
    rd_cmd(addr, 1, t);
    repeat (5) tick();
    chk({name, "_n"}, 128'(rq_dat.size()), 128'd1);
    chk({name, "_lat"}, 128'(rq_cyc[0]), 128'(t + LAT));
    chk({name, "_data"}, rq_dat[0], exp);
    exp_rd++;
  endtask

  initial begin
    int t;
    int wr_hi;
    int rc;
    int bad;
    errors = 0;
    checks = 0;
    exp_wr = 0;
    exp_rd = 0;

    vecs[0] = '{32'h20, {16{8'hA5}}, 16'hFFFF, {16{8'hA5}}};
    vecs[1] = '{32'h30, 128'h0, 16'hFFFF, 128'h0};
    vecs[2] = '{32'h30, {16{8'hFF}}, 16'h00F0,
                128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000};
    vecs[3] = '{32'h1035,
                128'h1111_1111_2222_2222_3333_3333_4444_4444,
                16'h000F,
                128'h0000_0000_0000_0000_FFFF_FFFF_4444_4444};
    vecs[4] = '{32'h20,
                128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
                16'h8001,
                128'h01A5_A5A5_A5A5_A5A5_A5A5_A5A5_A5A5_A510};

    rst              = 1'b1;
    m.avs_address    = '0;
    m.avs_burstcount = '0;
    m.avs_write      = 1'b0;
    m.avs_writedata  = '0;
    m.avs_byteenable = '0;
    m.avs_read       = 1'b0;

    repeat (3) tick();
    @(negedge clk);
    chk("rst_wait", 128'(m.avs_waitrequest), 128'd1);
    chk("rst_valid", 128'(m.avs_readdatavalid), 128'd0);
    chk("rst_rdata", m.avs_readdata, 128'd0);
    chk("rst_wcnt", 128'(wr_beat_cnt), 128'd0);
    chk("rst_rcnt", 128'(rd_beat_cnt), 128'd0);
    chk("rst_perr", 128'(proto_err), 128'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rel_wait", 128'(m.avs_waitrequest), 128'd0);
    tick();

    for (int i = 0; i < 5; i++) begin
      wr_beat(vecs[i].addr, 1, vecs[i].data, vecs[i].be);
      single_read($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      if (i == 0) begin
        @(negedge clk);
        chk("vec0_rcnt", 128'(rd_beat_cnt), 128'd1);
        tick();
      end
    end

    wr_beat(32'hFE0, 4, pat(0), 16'hFFFF);
    tick();
    for (int k = 1; k < 4; k++) begin
      wr_beat(32'h500, 4, pat(k), 16'hFFFF);
      tick();
    end
    rq_dat.delete();
    rq_cyc.delete();
    rd_cmd(32'hFE0, 4, t);
    wr_hi = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m.avs_waitrequest) wr_hi++;
      tick();
    end
    exp_rd += 4;
    chk("brst_wait", 128'(wr_hi), 128'd3);
    chk("brst_n", 128'(rq_dat.size()), 128'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("brst_d%0d", k), rq_dat[k], pat(k));
      chk($sformatf("brst_c%0d", k), 128'(rq_cyc[k]),
          128'(t + LAT + k));
    end
    single_read("wrap0", 32'h000, pat(2));
    single_read("wrap1", 32'h010, pat(3));

    @(negedge clk);
    chk("perr_pre", 128'(proto_err), 128'd0);
    tick();
    rq_dat.delete();
    rq_cyc.delete();
    m.avs_address    = 32'h50;
    m.avs_burstcount = 32'd1;
    m.avs_writedata  = {16{8'hC3}};
    m.avs_byteenable = 16'hFFFF;
    m.avs_write      = 1'b1;
    m.avs_read       = 1'b1;
    tick();
    m.avs_write = 1'b0;
    m.avs_read  = 1'b0;
    exp_wr++;
    repeat (5) tick();
    chk("wr_rd_drop", 128'(rq_dat.size()), 128'd0);
    chk("wr_rd_perr", 128'(proto_err), 128'd1);
    single_read("wr_rd_data", 32'h50, {16{8'hC3}});
    @(negedge clk);
    chk("wcnt", 128'(wr_beat_cnt), 128'(exp_wr));
    chk("rcnt", 128'(rd_beat_cnt), 128'(exp_rd));
    tick();

    rq_dat.delete();
    rq_cyc.delete();
    rd_cmd(32'h0, 8, t);
    tick();
    rst = 1'b1;
    rc  = cyc;
    @(negedge clk);
    chk("abort_wait", 128'(m.avs_waitrequest), 128'd1);
    tick();
    tick();
    rst = 1'b0;
    exp_wr = 0;
    exp_rd = 0;
    @(negedge clk);
    chk("abort_rel_wait", 128'(m.avs_waitrequest), 128'd0);
    chk("abort_valid", 128'(m.avs_readdatavalid), 128'd0);
    chk("abort_wcnt", 128'(wr_beat_cnt), 128'd0);
    chk("abort_rcnt", 128'(rd_beat_cnt), 128'd0);
    chk("abort_perr", 128'(proto_err), 128'd0);
    repeat (12) tick();
    bad = 0;
    foreach (rq_cyc[i]) if (rq_cyc[i] > rc) bad++;
    chk("abort_flush", 128'(bad), 128'd0);

    rq_dat.delete();
    rq_cyc.delete();
    rd_cmd(32'h0, 100, t);
    repeat (64 + LAT + 10) tick();
    chk("clamp_n", 128'(rq_dat.size()), 128'd64);
    chk("clamp_d0", rq_dat[0], pat(2));
    chk("clamp_d1", rq_dat[1], pat(3));
    chk("clamp_d2", rq_dat[2], vecs[4].exp);
    chk("clamp_last", 128'(rq_cyc[63]), 128'(t + LAT + 63));
    @(negedge clk);
    chk("clamp_perr", 128'(proto_err), 128'd1);
    chk("clamp_rcnt", 128'(rd_beat_cnt), 128'd64);
    chk("clamp_wait", 128'(m.avs_waitrequest), 128'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
